collatz_engine: RTL and testbench

// Parametrised Collatz iteration engine, the next generation of the single-value

---
 rtl/collatz_engine.sv | 115 +++++++++++
 tb/tb_collatz_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/collatz_engine.sv
// Collatz iteration engine: accepts a start value, performs one Collatz step
// per clock and returns step count, peak, final value and overflow/saturation
// flags over a valid/ready result handshake.
module collatz_engine #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_n,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_steps,
    output logic [WIDTH-1:0] res_peak,
    output logic [WIDTH-1:0] res_last,
    output logic             res_ovf,
    output logic             res_sat
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] steps;
        logic [WIDTH-1:0] peak;
        logic [WIDTH-1:0] cur;
        logic             ovf;
        logic             sat;
    } res_t;

    state_t           state, state_nxt;
    res_t             r;
    logic [WIDTH+1:0] nxt;
    logic             at_end, cnt_full, nxt_big;

    // Candidate next value, two guard bits so 3x+1 overflow is visible
    always_comb begin
        nxt = '0;
        if (r.cur[0])
            nxt = {2'b00, r.cur} + {1'b0, r.cur, 1'b0} + (WIDTH+2)'(1);
        else
            nxt = {3'b000, r.cur[WIDTH-1:1]};
        at_end   = (r.cur <= WIDTH'(1));
        cnt_full = &r.steps;
        nxt_big  = |nxt[WIDTH+1:WIDTH];
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs; termination priority: end, saturate, overflow
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nxt = RUN;
            end
            RUN: begin
                if (at_end || cnt_full || nxt_big) state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration datapath; result registers frozen outside IDLE/RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        r.cur   <= start_n;
                        r.peak  <= start_n;
                        r.steps <= '0;
                        r.ovf   <= 1'b0;
                        r.sat   <= 1'b0;
                    end
                end
                RUN: begin
                    if (at_end) begin
                        // terminal value reached, nothing to update
                    end else if (cnt_full) begin
                        r.sat <= 1'b1;
                    end else if (nxt_big) begin
                        r.ovf <= 1'b1;
                    end else begin
                        r.cur   <= nxt[WIDTH-1:0];
                        r.steps <= r.steps + CNT_W'(1);
                        if (nxt[WIDTH-1:0] > r.peak) r.peak <= nxt[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_steps = r.steps;
    assign res_peak  = r.peak;
    assign res_last  = r.cur;
    assign res_ovf   = r.ovf;
    assign res_sat   = r.sat;

endmodule

// File: tb/tb_collatz_engine.sv
// Bench for collatz_engine: three instances (32/16, 8/16, 16/4) checked
// against an arithmetic Collatz reference model.
module tb_collatz_engine;

    localparam int NI = 3;

    function automatic int wof(input int g);
        return (g == 1) ? 8 : ((g == 2) ? 16 : 32);
    endfunction

    function automatic int cof(input int g);
        return (g == 2) ? 4 : 16;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        sv   [NI];
    logic        rr   [NI];
    logic [31:0] sn   [NI];
    logic        srdy [NI];
    logic        rv   [NI];
    logic        rovf [NI];
    logic        rsat [NI];
    logic [31:0] rstp [NI];
    logic [31:0] rpk  [NI];
    logic [31:0] rlst [NI];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [cof(g)-1:0] st;
        logic [wof(g)-1:0] pk, ls, n;
        assign n = sn[g][wof(g)-1:0];
        collatz_engine #(.WIDTH(wof(g)), .CNT_W(cof(g))) dut (
            .clk(clk), .rst(rst),
            .start_valid(sv[g]), .start_ready(srdy[g]), .start_n(n),
            .res_valid(rv[g]), .res_ready(rr[g]),
            .res_steps(st), .res_peak(pk), .res_last(ls),
            .res_ovf(rovf[g]), .res_sat(rsat[g])
        );
        assign rstp[g] = 32'(st);
        assign rpk[g]  = 32'(pk);
        assign rlst[g] = 32'(ls);
    end

    // Reference: iterate the Collatz rules with plain wide arithmetic
    task automatic model(input int w, input int c, input longint n,
                         output longint st, output longint pk, output longint ls,
                         output bit ov, output bit sa);
        longint cur, nx;
        cur = n; st = 0; pk = n; ov = 0; sa = 0;
        while (1) begin
            if (cur <= 1) break;
            if (st == (longint'(1) << c) - 1) begin sa = 1; break; end
            nx = (cur % 2 == 1) ? 3 * cur + 1 : cur / 2;
            if (nx >= (longint'(1) << w)) begin ov = 1; break; end
            cur = nx;
            st++;
            if (nx > pk) pk = nx;
        end
        ls = cur;
    endtask

    task automatic run_check(input int k, input longint n, input string nm);
        longint est, epk, els;
        bit     eov, esa, got;
        int     lat;
        model(wof(k), cof(k), n, est, epk, els, eov, esa);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (srdy[k]) begin got = 1; break; end
            @(posedge clk); #1;
        end
        nvec++;
        if (!got) begin nerr++; $display("FAIL %s ready timeout: start_ready stayed 0", nm); return; end
        sv[k] = 1'b1; sn[k] = n[31:0];
        @(posedge clk); #1;
        sv[k] = 1'b0;
        lat = 0; got = 0;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk); #1;
            lat++;
            if (rv[k]) begin got = 1; break; end
        end
        nvec++;
        if (!got) begin nerr++; $display("FAIL %s result timeout: res_valid never rose", nm); return; end
        nvec++;
        if (lat != est + 1) begin nerr++; $display("FAIL %s latency: got %0d want %0d", nm, lat, est + 1); end
        nvec++;
        if (rstp[k] !== est[31:0]) begin nerr++; $display("FAIL %s steps: got %0d want %0d", nm, rstp[k], est); end
        nvec++;
        if (rpk[k] !== epk[31:0]) begin nerr++; $display("FAIL %s peak: got %0d want %0d", nm, rpk[k], epk); end
        nvec++;
        if (rlst[k] !== els[31:0]) begin nerr++; $display("FAIL %s last: got %0d want %0d", nm, rlst[k], els); end
        nvec++;
        if (rovf[k] !== eov || rsat[k] !== esa) begin
            nerr++; $display("FAIL %s flags: got ovf=%0b sat=%0b want ovf=%0b sat=%0b", nm, rovf[k], rsat[k], eov, esa);
        end
        if (rr[k]) begin
            @(posedge clk); #1;
            nvec++;
            if (rv[k] !== 1'b0 || srdy[k] !== 1'b1) begin
                nerr++; $display("FAIL %s handshake: got valid=%0b ready=%0b want valid=0 ready=1", nm, rv[k], srdy[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) begin
            nvec++;
            if (srdy[k] !== 1'b1 || rv[k] !== 1'b0 || rstp[k] !== 0 || rpk[k] !== 0 ||
                rlst[k] !== 0 || rovf[k] !== 1'b0 || rsat[k] !== 1'b0) begin
                nerr++;
                $display("FAIL reset[%0d]: got ready=%0b valid=%0b steps=%0d peak=%0d last=%0d ovf=%0b sat=%0b want 1 0 0 0 0 0 0",
                         k, srdy[k], rv[k], rstp[k], rpk[k], rlst[k], rovf[k], rsat[k]);
            end
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_check(0, 6, "n6");
        run_check(0, 27, "n27");
        run_check(0, 1, "n1");
        run_check(0, 0, "n0");
        run_check(1, 255, "w8_n255_ovf");
        run_check(2, 27, "c4_n27_sat");
        run_check(0, 32'hFFFF_FFFF, "w32_max");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_check(0, (i % 2 == 0) ? longint'($urandom_range(2, 5000)) : longint'($urandom), "rand32");
        for (int i = 0; i < 15; i++) run_check(1, longint'($urandom_range(0, 255)), "rand8");
        for (int i = 0; i < 15; i++) run_check(2, longint'($urandom_range(0, 65535)), "rand16");
    endtask

    task automatic test_backpressure();
        bit got;
        rr[0] = 1'b0;
        run_check(0, 6, "bp_n6");
        for (int i = 0; i < 5; i++) begin
            sv[0] = (i % 2 == 0); sn[0] = 32'd99;
            @(posedge clk); #1;
            nvec++;
            if (rv[0] !== 1'b1 || srdy[0] !== 1'b0 || rstp[0] !== 8 || rpk[0] !== 16 ||
                rlst[0] !== 1 || rovf[0] !== 1'b0 || rsat[0] !== 1'b0) begin
                nerr++;
                $display("FAIL bp_hold[%0d]: got valid=%0b ready=%0b steps=%0d peak=%0d last=%0d want 1 0 8 16 1",
                         i, rv[0], srdy[0], rstp[0], rpk[0], rlst[0]);
            end
        end
        sv[0] = 1'b0;
        rr[0] = 1'b1;
        @(posedge clk); #1;
        nvec++;
        if (rv[0] !== 1'b0 || srdy[0] !== 1'b1) begin
            nerr++; $display("FAIL bp_release: got valid=%0b ready=%0b want 0 1", rv[0], srdy[0]);
        end
        @(posedge clk); #1;
        got = srdy[0];
        nvec++;
        if (got !== 1'b1) begin nerr++; $display("FAIL bp_no_queue: got ready=%0b want 1", got); end
    endtask

    task automatic test_reset_mid();
        sv[0] = 1'b1; sn[0] = 32'd27;
        @(posedge clk); #1;
        sv[0] = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (rv[0] !== 1'b0 || srdy[0] !== 1'b1 || rstp[0] !== 0 || rpk[0] !== 0 || rlst[0] !== 0) begin
            nerr++;
            $display("FAIL reset_mid: got valid=%0b ready=%0b steps=%0d peak=%0d last=%0d want 0 1 0 0 0",
                     rv[0], srdy[0], rstp[0], rpk[0], rlst[0]);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_check(0, 6, "after_reset_n6");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) run_check(0, longint'(i + 3), "b2b");
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin sv[k] = 1'b0; rr[k] = 1'b1; sn[k] = '0; end
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
